// File: rtl/game_step_ctrl_if.sv
// Button inputs and game-state outputs of game_step_ctrl, bundled.
//   btn_move   : raw pushbutton, advances the cursor
//   btn_select : raw pushbutton, confirms the cursor
//   step       : game phase 0..6
//   variety    : first-pick square index 0..3
//   match      : second-pick square index 0..3
//   variety1   : cursor/pick within the remaining pair 0..3
//   busy       : high while a display-hold timer runs
// The slave modport is the controller; the master modport drives the buttons.
interface game_step_ctrl_if;
   logic       btn_move;
   logic       btn_select;
   logic [2:0] step;
   logic [2:0] variety;
   logic [2:0] match;
   logic [2:0] variety1;
   logic       busy;

   modport master (
      output btn_move, btn_select,
      input  step, variety, match, variety1, busy
   );

   modport slave (
      input  btn_move, btn_select,
      output step, variety, match, variety1, busy
   );
endinterface

// File: rtl/game_step_ctrl.sv
// Two-button pair-matching game sequencer.
// Ports:
//   clk25MHz : sole clock, rising edge
//   reset    : synchronous, active-high
//   bus      : game_step_ctrl_if.slave (raw buttons in, registered game state out)
// Each raw button is synchronized, debounced by a consecutive-cycle counter and
// edge-detected into a single-cycle pulse that drives the phase machine.
module game_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned HOLD_CYCLES     = 25000000
) (
   input logic             clk25MHz,
   input logic             reset,
   game_step_ctrl_if.slave bus
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;
   localparam logic [2:0] S5 = 3'd5;
   localparam logic [2:0] S6 = 3'd6;

   // ---------------------------------------------------------------
   // Button conditioning, bit 0 = move, bit 1 = select
   // ---------------------------------------------------------------
   logic [1:0]     raw;
   logic [1:0]     sync1_q, sync2_q;
   logic [1:0]     filt_q, filt_prev_q;
   logic [DBW-1:0] cnt_q [2];
   logic [1:0]     rise;
   logic           mv_p, sel_p;

   assign raw = {bus.btn_select, bus.btn_move};

   always_ff @(posedge clk25MHz) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         filt_q      <= '0;
         filt_prev_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q     <= raw;
         sync2_q     <= sync1_q;
         filt_prev_q <= filt_q;
         for (int i = 0; i < 2; i++) begin
            // Count cycles spent at the opposite level; any return restarts it.
            if (sync2_q[i] == filt_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DB_LAST) begin
               filt_q[i] <= sync2_q[i];
               cnt_q[i]  <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign rise  = filt_q & ~filt_prev_q;
   assign sel_p = rise[1];
   assign mv_p  = rise[0] & ~rise[1];   // select wins a same-cycle collision

   // ---------------------------------------------------------------
   // Phase machine
   // ---------------------------------------------------------------
   logic [2:0]    step_q, step_d;
   logic [1:0]    variety_q, variety_d;
   logic [1:0]    match_q, match_d;
   logic [1:0]    v1_q, v1_d;
   logic          busy_q, busy_d;
   logic [HW-1:0] timer_q, timer_d;
   logic          hold_done;
   logic [1:0]    match_inc;
   logic          pair_ok;

   assign hold_done = busy_q && (timer_q == '0);
   assign match_inc = match_q + 2'd1;
   assign pair_ok   = ({1'b0, variety_q} + {1'b0, match_q}) == 3'd3;

   always_comb begin
      step_d    = step_q;
      variety_d = variety_q;
      match_d   = match_q;
      v1_d      = v1_q;
      busy_d    = busy_q;
      timer_d   = timer_q;
      if (busy_q && (timer_q != '0)) timer_d = timer_q - 1'b1;

      case (step_q)
         S0: begin
            if (sel_p) begin
               match_d = (variety_q != 2'd0) ? 2'd0 : 2'd1;
               step_d  = S1;
            end else if (mv_p) begin
               variety_d = variety_q + 2'd1;
            end
         end
         S1: begin
            if (sel_p) begin
               step_d  = S2;
               busy_d  = 1'b1;
               timer_d = HOLD_LAST;
            end else if (mv_p) begin
               match_d = (match_inc == variety_q) ? match_q + 2'd2 : match_inc;
            end
         end
         S2: begin
            if (hold_done) begin
               busy_d = 1'b0;
               if (pair_ok) begin
                  step_d = S3;
                  // Remaining pair is B-C when A-D was found, else A-D.
                  v1_d   = (variety_q == 2'd0 || variety_q == 2'd3) ? 2'd1 : 2'd0;
               end else begin
                  step_d    = S0;
                  variety_d = 2'd0;
                  match_d   = 2'd0;
               end
            end
         end
         S3: begin
            if (sel_p) begin
               step_d = S4;
            end else if (mv_p) begin
               v1_d = v1_q ^ 2'b11;   // 1<->2 or 0<->3
            end
         end
         S4: begin
            if (sel_p) begin
               step_d  = S5;
               busy_d  = 1'b1;
               timer_d = HOLD_LAST;
            end
         end
         S5: begin
            if (hold_done) begin
               busy_d = 1'b0;
               step_d = S6;
            end
         end
         S6: ;
         default: begin
            step_d = S0;
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk25MHz) begin
      if (reset) begin
         step_q    <= S0;
         variety_q <= 2'd0;
         match_q   <= 2'd0;
         v1_q      <= 2'd0;
         busy_q    <= 1'b0;
         timer_q   <= '0;
      end else begin
         step_q    <= step_d;
         variety_q <= variety_d;
         match_q   <= match_d;
         v1_q      <= v1_d;
         busy_q    <= busy_d;
         timer_q   <= timer_d;
      end
   end

   assign bus.step     = step_q;
   assign bus.variety  = {1'b0, variety_q};
   assign bus.match    = {1'b0, match_q};
   assign bus.variety1 = {1'b0, v1_q};
   assign bus.busy     = busy_q;

endmodule

// File: doc/game_step_ctrl.md
GAME_STEP_CTRL -- requirements
Module: game_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, stable-high/low cycles needed to accept a button level (10 ms at 25 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25000000, display-hold duration in cycles (1 s at 25 MHz).
REQ-003 clk25MHz  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_move  input  1  raw asynchronous pushbutton, advances cursor.
REQ-006 btn_select  input  1  raw asynchronous pushbutton, confirms cursor.
REQ-007 step  output  3  game phase, values 0..6, consumed by square-action stage.
REQ-008 variety  output  3  first-pick square index 0..3 (A..D), MSB always 0.
REQ-009 match  output  3  second-pick square index 0..3, MSB always 0.
REQ-010 variety1  output  3  cursor/pick in remaining pair, 0..3, MSB always 0.
REQ-011 busy  output  1  high while a display-hold timer runs.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a counter debouncer: filtered level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level.
REQ-013 Rising edge of each filtered level SHALL yield a one-cycle pulse (mv_p, sel_p); one press yields exactly one pulse.
REQ-014 mv_p and sel_p in the same cycle: sel_p SHALL act, mv_p SHALL be discarded.
REQ-015 Fixed pairs: A(0)-D(3), B(1)-C(2); pair correct iff variety+match == 3.
REQ-016 S0 (step=0): mv_p sets variety=(variety+1) mod 4; sel_p sets match = 0 if variety!=0 else 1, step=1.
REQ-017 S1 (step=1): mv_p advances match mod 4 skipping variety value; sel_p sets step=2, starts hold timer.
REQ-018 S2 (step=2): buttons ignored; after HOLD_CYCLES, correct pair -> step=3, variety1 = lower index of other pair (1 if pair A-D, 0 if B-C); wrong pair -> step=0, variety=0, match=0.
REQ-019 S3 (step=3): mv_p toggles variety1 between the two remaining indices; sel_p sets step=4.
REQ-020 S4 (step=4): mv_p ignored; sel_p sets step=5, starts hold timer.
REQ-021 S5 (step=5): buttons ignored; after HOLD_CYCLES, step=6.
REQ-022 S6 (step=6): terminal, all buttons ignored, outputs frozen until reset.
REQ-023 Hold timer SHALL count exactly HOLD_CYCLES cycles from the sel_p cycle to the step-change edge; busy=1 for exactly those cycles.
REQ-024 Outputs SHALL be registered; step and index updates take effect the cycle after the accepting pulse.
REQ-025 step values 7 unreachable; if ever present, next cycle SHALL force step=0.
REQ-026 All index arithmetic 2-bit modulo 4, zero-extended to 3 bits.

Reset
REQ-027 reset=1 at any cycle, including mid-hold or mid-debounce, SHALL next edge set step=0, variety=0, match=0, variety1=0, busy=0, clear timers, debounce counters and filtered levels to 0.
REQ-028 A button held through reset release SHALL need a full debounce period and produces one pulse.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-029 Reset, 3 move presses -> variety 0->1->2->3, step stays 0; glitch of 2 cycles -> no change.
REQ-030 variety=0, select, move x3 -> step=1, match 1->2->3->1 (0 skipped).
REQ-031 variety=0, match=3, select -> step=2, busy 8 cycles, then step=3, variety1=1; move -> variety1=2; select -> step=4; select -> step=5; 8 cycles -> step=6; further presses -> no change.
REQ-032 variety=1, match=3, select -> 8 cycles hold then step=0, variety=0, match=0.
REQ-033 move and select pulses same cycle in S0 with variety=2 -> step=1, variety=2, match=0.
REQ-034 reset asserted during S2 hold cycle 4 -> next cycle all outputs 0, busy=0, no later step change.
